// File: rtl/xor_frame_checksum.sv
// xor_frame_checksum
//   Streaming XOR checksum unit. Folds a frame of WIDTH-bit words into a
//   running XOR, counts the words (saturating), and presents the per-frame
//   checksum, its parity and a zero-check through a valid/ready output
//   register.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   clear         synchronous frame abort (drops partial frame and pending result)
//   in_valid      in_data/in_last valid
//   in_ready      beat can be accepted this cycle (combinational)
//   in_data       data word
//   in_last       final word of frame
//   out_valid     result registers hold an unconsumed frame result
//   out_ready     consumer takes the result this cycle
//   out_checksum  XOR of all words in the frame
//   out_parity    XOR-reduction of out_checksum
//   out_zero      out_checksum == 0
//   out_count     words in frame, saturating at 2^CNT_W-1
//   out_sat       word count saturated during this frame
module xor_frame_checksum #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_checksum,
  output logic             out_parity,
  output logic             out_zero,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_q, sat_d;
  logic               vld_q, vld_d;
  logic [WIDTH-1:0]   ck_q, ck_d;
  logic               par_q, par_d;
  logic               zero_q, zero_d;
  logic [CNT_W-1:0]   ocnt_q, ocnt_d;
  logic               osat_q, osat_d;

  logic               accept;
  logic               cnt_at_max;
  logic [CNT_W-1:0]   cnt_inc;
  logic [WIDTH-1:0]   fold;

  // A pending result blocks input unless it is being consumed this cycle,
  // which lets frames stream back-to-back without a bubble.
  assign in_ready   = reset && !clear && (!vld_q || out_ready);
  assign accept     = in_valid && in_ready;
  assign cnt_at_max = (cnt_q == CNT_MAX);
  assign cnt_inc    = cnt_at_max ? cnt_q : cnt_q + CNT_ONE;
  assign fold       = acc_q ^ in_data;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    vld_d   = vld_q;
    ck_d    = ck_q;
    par_d   = par_q;
    zero_d  = zero_q;
    ocnt_d  = ocnt_q;
    osat_d  = osat_q;

    if (clear) begin
      // Abort: open frame and pending result dropped; result data kept.
      acc_d   = '0;
      cnt_d   = '0;
      sat_d   = 1'b0;
      vld_d   = 1'b0;
      state_d = IDLE;
    end else begin
      if (vld_q && out_ready) begin
        vld_d   = 1'b0;
        state_d = IDLE;
      end
      if (accept) begin
        if (in_last) begin
          ck_d    = fold;
          par_d   = ^fold;
          zero_d  = (fold == '0);
          ocnt_d  = cnt_inc;
          osat_d  = sat_q | cnt_at_max;
          vld_d   = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
          state_d = HOLD;
        end else begin
          acc_d   = fold;
          cnt_d   = cnt_inc;
          sat_d   = sat_q | cnt_at_max;
          state_d = ACCUM;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      vld_q   <= 1'b0;
      ck_q    <= '0;
      par_q   <= 1'b0;
      zero_q  <= 1'b1;
      ocnt_q  <= '0;
      osat_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      vld_q   <= vld_d;
      ck_q    <= ck_d;
      par_q   <= par_d;
      zero_q  <= zero_d;
      ocnt_q  <= ocnt_d;
      osat_q  <= osat_d;
    end
  end

  assign out_valid    = vld_q;
  assign out_checksum = ck_q;
  assign out_parity   = par_q;
  assign out_zero     = zero_q;
  assign out_count    = ocnt_q;
  assign out_sat      = osat_q;

endmodule

// File: tb/tb_xor_frame_checksum.sv
// Testbench for xor_frame_checksum. Two instances (16-bit and 2-bit word
// counters) share one input stream; a frame-level reference model keeps the
// words of the open frame in a queue and folds them when the last word is
// accepted.
module tb_xor_frame_checksum;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n, clear, in_valid, in_last, out_ready;
  logic [W-1:0] in_data;

  logic         rdy_a, vld_a, par_a, zero_a, sat_a;
  logic         rdy_b, vld_b, par_b, zero_b, sat_b;
  logic [W-1:0] ck_a, ck_b;
  logic [15:0]  cnt_a;
  logic [1:0]   cnt_b;

  int compared = 0;
  int mism     = 0;

  // Reference model state
  logic [W-1:0] frame_q[$];
  bit           m_valid;
  logic [W-1:0] m_ck;
  int           m_len;

  always #5 clk = ~clk;

  xor_frame_checksum #(.WIDTH(W), .CNT_W(16)) dut_a (
    .clk(clk), .reset(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(rdy_a), .in_data(in_data), .in_last(in_last),
    .out_valid(vld_a), .out_ready(out_ready), .out_checksum(ck_a),
    .out_parity(par_a), .out_zero(zero_a), .out_count(cnt_a), .out_sat(sat_a)
  );

  xor_frame_checksum #(.WIDTH(W), .CNT_W(2)) dut_b (
    .clk(clk), .reset(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(rdy_b), .in_data(in_data), .in_last(in_last),
    .out_valid(vld_b), .out_ready(out_ready), .out_checksum(ck_b),
    .out_parity(par_b), .out_zero(zero_b), .out_count(cnt_b), .out_sat(sat_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    frame_q.delete();
    m_valid = 1'b0;
    m_ck    = '0;
    m_len   = 0;
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".valid_a"},  vld_a,  m_valid);
    chk({tag, ".valid_b"},  vld_b,  m_valid);
    chk({tag, ".ck_a"},     ck_a,   m_ck);
    chk({tag, ".ck_b"},     ck_b,   m_ck);
    chk({tag, ".par_a"},    par_a,  ^m_ck);
    chk({tag, ".zero_a"},   zero_a, (m_ck == 0));
    chk({tag, ".zero_b"},   zero_b, (m_ck == 0));
    chk({tag, ".cnt_a"},    cnt_a,  (m_len > 65535) ? 65535 : m_len);
    chk({tag, ".sat_a"},    sat_a,  (m_len > 65535));
    chk({tag, ".cnt_b"},    cnt_b,  (m_len > 3) ? 3 : m_len);
    chk({tag, ".sat_b"},    sat_b,  (m_len > 3));
    chk({tag, ".par_b"},    par_b,  ^m_ck);
  endtask

  // One clock cycle: drive inputs after the falling edge, check in_ready,
  // advance the model, then check registered outputs 1 time unit after the
  // rising edge. Returns at the next falling edge.
  task automatic tick(input bit v, input logic [W-1:0] d, input bit l,
                      input bit ordy, input bit clr);
    bit exp_rdy;
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = ordy;
    clear     = clr;
    #1;
    exp_rdy = !clr && (!m_valid || ordy);
    chk("in_ready_a", rdy_a, exp_rdy);
    chk("in_ready_b", rdy_b, exp_rdy);
    if (clr) begin
      frame_q.delete();
      m_valid = 1'b0;
    end else begin
      if (m_valid && ordy) m_valid = 1'b0;
      if (v && exp_rdy) begin
        frame_q.push_back(d);
        if (l) begin
          m_ck = '0;
          foreach (frame_q[i]) m_ck ^= frame_q[i];
          m_len = frame_q.size();
          frame_q.delete();
          m_valid = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    check_outs("cyc");
    @(negedge clk);
  endtask

  // Asynchronous reset pulse, starting mid-cycle after a falling edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outs("rst_async");
    chk("rst_in_ready_a", rdy_a, 1'b0);
    chk("rst_in_ready_b", rdy_b, 1'b0);
    @(posedge clk);
    #1;
    check_outs("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outs("reset");
    chk("reset_in_ready_a", rdy_a, 1'b0);
    rst_n = 1'b1;

    // Frame 0x0F, 0xF0, last 0xFF -> checksum 0, count 3
    tick(1, 8'h0F, 0, 1, 0);
    tick(1, 8'hF0, 0, 1, 0);
    tick(1, 8'hFF, 1, 1, 0);
    chk("t1_ck",    ck_a,   8'h00);
    chk("t1_zero",  zero_a, 1'b1);
    chk("t1_par",   par_a,  1'b0);
    chk("t1_cnt",   cnt_a,  16'd3);
    chk("t1_valid", vld_a,  1'b1);
    tick(0, 8'h00, 0, 1, 0);

    // Single word with the consumer stalled for 4 cycles
    tick(1, 8'h01, 1, 0, 0);
    chk("t2_ck",  ck_a,  8'h01);
    chk("t2_par", par_a, 1'b1);
    chk("t2_cnt", cnt_a, 16'd1);
    repeat (4) tick(1, 8'h77, 0, 0, 0);
    chk("t2_stall_ck", ck_a, 8'h01);
    tick(0, 8'h00, 0, 1, 0);
    chk("t2_drained", vld_a, 1'b0);

    // Back-to-back frames {0x12, last 0x34}, {last 0x56}
    tick(1, 8'h12, 0, 1, 0);
    tick(1, 8'h34, 1, 1, 0);
    chk("t3_ck0",  ck_a,  8'h26);
    chk("t3_cnt0", cnt_a, 16'd2);
    tick(1, 8'h56, 1, 1, 0);
    chk("t3_ck1",  ck_a,  8'h56);
    chk("t3_cnt1", cnt_a, 16'd1);
    chk("t3_vld1", vld_a, 1'b1);
    tick(0, 8'h00, 0, 1, 0);

    // Five words of 0xAA: 2-bit counter saturates at 3
    for (int i = 0; i < 5; i++) tick(1, 8'hAA, (i == 4), 1, 0);
    chk("t4_ck",    ck_b,  8'hAA);
    chk("t4_cnt_b", cnt_b, 2'd3);
    chk("t4_sat_b", sat_b, 1'b1);
    chk("t4_cnt_a", cnt_a, 16'd5);
    tick(1, 8'h5A, 1, 1, 0);
    chk("t4_sat_b_next", sat_b, 1'b0);
    chk("t4_cnt_b_next", cnt_b, 2'd1);
    tick(0, 8'h00, 0, 1, 0);

    // Clear mid-frame with a beat presented during clear
    tick(1, 8'h11, 0, 1, 0);
    tick(1, 8'h22, 0, 1, 0);
    tick(1, 8'h99, 0, 1, 1);
    tick(1, 8'h33, 1, 1, 0);
    chk("t5_ck",  ck_a,  8'h33);
    chk("t5_cnt", cnt_a, 16'd1);

    // Reset mid-frame, then reset while holding a result
    tick(1, 8'h44, 0, 1, 0);
    do_reset();
    tick(1, 8'h55, 1, 0, 0);
    chk("t6_hold", vld_a, 1'b1);
    do_reset();
    tick(0, 8'h00, 0, 1, 0);
    chk("t6_no_stale", vld_a, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 150) == 0) do_reset();
      tick($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 4) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
